// File: rtl/sec_bcd_conv.sv
// Binary-to-BCD converter for the seconds counter: iterative double dabble, one bit per cycle.
// Accept-to-result latency is WIDTH cycles; the result is held in DONE until Out_ready takes it.
module sec_bcd_conv #(
   parameter int WIDTH  = 64,
   parameter int DIGITS = 20
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  In_valid,
   output logic                  In_ready,
   input  logic [WIDTH-1:0]      Din,
   output logic                  Out_valid,
   input  logic                  Out_ready,
   output logic [4*DIGITS-1:0]   Bcd,
   output logic [4:0]            Digits
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t               state;
   logic [4*DIGITS-1:0]  work;
   logic [4*DIGITS-1:0]  adj;
   logic [4*DIGITS-1:0]  nxt_work;
   logic [WIDTH-1:0]     shreg;
   logic [CW-1:0]        cnt;
   logic [4:0]           ndig;

   assign In_ready = (state == IDLE);

   // Digits are <=9 before the add, so the 4-bit +3 never carries out.
   always_comb begin
      adj = work;
      for (int i = 0; i < DIGITS; i++) begin
         if (work[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end
      nxt_work = {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
      ndig = 5'd1;
      for (int i = 0; i < DIGITS; i++) begin
         if (nxt_work[4*i +: 4] != 4'd0)
            ndig = 5'(i + 1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         work      <= '0;
         shreg     <= '0;
         cnt       <= '0;
         Bcd       <= '0;
         Digits    <= 5'd1;
         Out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (In_valid) begin
                  shreg <= Din;
                  work  <= '0;
                  cnt   <= CW'(WIDTH);
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               work  <= nxt_work;
               shreg <= {shreg[WIDTH-2:0], 1'b0};
               cnt   <= cnt - CW'(1);
               // Last shift: publish straight from the next-state value.
               if (cnt == CW'(1)) begin
                  Bcd       <= nxt_work;
                  Digits    <= ndig;
                  Out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (Out_ready) begin
                  Out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sec_bcd_conv.sv
// Bench for sec_bcd_conv: directed corner cases plus randomized values,
// checked against a decimal-string reference built with $sformatf("%0d").
module tb_sec_bcd_conv;

   logic         Clk = 1'b0;
   logic         Reset;
   logic         In_valid;
   logic         In_ready;
   logic [63:0]  Din;
   logic         Out_valid;
   logic         Out_ready;
   logic [79:0]  Bcd;
   logic [4:0]   Digits;

   int tests = 0;
   int fails = 0;

   sec_bcd_conv #(.WIDTH(64), .DIGITS(20)) dut (
      .Clk(Clk), .Reset(Reset), .In_valid(In_valid), .In_ready(In_ready),
      .Din(Din), .Out_valid(Out_valid), .Out_ready(Out_ready),
      .Bcd(Bcd), .Digits(Digits)
   );

   always #5 Clk = ~Clk;

   // Decimal text of the value, one BCD nibble per character.
   task automatic ref_model(input logic [63:0] v, output logic [79:0] b, output int nd);
      string s;
      s = $sformatf("%0d", v);
      b = '0;
      for (int i = 0; i < s.len(); i++)
         b = {b[75:0], 4'(s[i] - 8'h30)};
      nd = s.len();
   endtask

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Handshake one value in, wait for the result, leave the DUT in DONE.
   task automatic convert(input logic [63:0] v, input string tag);
      int n;
      int ed;
      logic [79:0] eb;
      ref_model(v, eb, ed);
      check({tag, " in_ready"}, 128'(In_ready), 128'(1));
      Din = v;
      In_valid = 1'b1;
      @(posedge Clk); #1;
      In_valid = 1'b0;
      Din = '0;
      n = 0;
      while (!Out_valid && n < 200) begin
         @(posedge Clk); #1;
         n++;
      end
      check({tag, " latency"}, 128'(n), 128'(64));
      check({tag, " bcd"}, 128'(Bcd), 128'(eb));
      check({tag, " digits"}, 128'(Digits), 128'(ed));
   endtask

   task automatic release_out(input string tag);
      Out_ready = 1'b1;
      @(posedge Clk); #1;
      Out_ready = 1'b0;
      check({tag, " rel out_valid"}, 128'(Out_valid), 128'(0));
      check({tag, " rel in_ready"}, 128'(In_ready), 128'(1));
   endtask

   initial begin
      logic [79:0] eb;
      int          ed;
      logic [63:0] live;
      logic [63:0] q[$];
      int          last_acc;
      int          outs;
      int          cyc;

      Reset = 1'b1; In_valid = 1'b1; Din = 64'd5; Out_ready = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      Reset = 1'b0; In_valid = 1'b0; Din = '0;
      check("rst out_valid", 128'(Out_valid), 128'(0));
      check("rst bcd", 128'(Bcd), 128'(0));
      check("rst digits", 128'(Digits), 128'(1));
      check("rst in_ready", 128'(In_ready), 128'(1));

      convert(64'd0, "zero");
      release_out("zero");
      convert(64'd1234567890, "dec10");
      check("dec10 literal", 128'(Bcd), 128'(80'h1234567890));
      release_out("dec10");
      convert(64'hFFFF_FFFF_FFFF_FFFF, "max");
      check("max literal", 128'(Bcd), 128'(80'h18446744073709551615));

      // Stall in DONE with a competing input that must be ignored.
      ref_model(64'hFFFF_FFFF_FFFF_FFFF, eb, ed);
      In_valid = 1'b1; Din = 64'd7;
      for (int i = 0; i < 10; i++) begin
         @(posedge Clk); #1;
         check("hold out_valid", 128'(Out_valid), 128'(1));
         check("hold bcd", 128'(Bcd), 128'(eb));
         check("hold digits", 128'(Digits), 128'(ed));
         check("hold in_ready", 128'(In_ready), 128'(0));
      end
      In_valid = 1'b0; Din = '0;
      release_out("hold");
      check("hold no capture", 128'(Bcd), 128'(eb));

      // Reset in the middle of a conversion.
      Din = 64'd999; In_valid = 1'b1;
      @(posedge Clk); #1;
      In_valid = 1'b0;
      repeat (30) @(posedge Clk);
      #1;
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0;
      check("abort out_valid", 128'(Out_valid), 128'(0));
      check("abort bcd", 128'(Bcd), 128'(0));
      check("abort digits", 128'(Digits), 128'(1));
      check("abort in_ready", 128'(In_ready), 128'(1));
      convert(64'd42, "after abort");
      check("42 literal", 128'(Bcd), 128'(80'h42));
      release_out("42");

      for (int k = 0; k < 6; k++) begin
         convert({$urandom, $urandom} >> $urandom_range(63, 0), "rand");
         release_out("rand");
      end

      // Streaming from a free-running seconds counter, both sides always ready.
      live = {$urandom, $urandom};
      Out_ready = 1'b1;
      In_valid = 1'b1;
      last_acc = -1;
      outs = 0;
      cyc = 0;
      while (outs < 8 && cyc < 2000) begin
         Din = live;
         live = live + 64'd1;
         if (In_ready) begin
            q.push_back(Din);
            if (last_acc >= 0)
               check("stream period", 128'(cyc - last_acc), 128'(66));
            last_acc = cyc;
         end
         if (Out_valid) begin
            if (q.size() == 0) begin
               check("stream spurious", 128'(1), 128'(0));
            end else begin
               ref_model(q.pop_front(), eb, ed);
               check("stream bcd", 128'(Bcd), 128'(eb));
               check("stream digits", 128'(Digits), 128'(ed));
            end
            outs++;
         end
         @(posedge Clk); #1;
         cyc++;
      end
      check("stream results", 128'(outs), 128'(8));
      In_valid = 1'b0;
      Out_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
